seven_seg_scan: RTL and testbench

Parametrised, time-multiplexed seven-segment display driver for the digital clock. It captures NUM_DIGITS BCD digits into a shadow register and scans them one digit at a time onto a shared active-low segment bus with active-low anode enables. It also provides:

- a one-cycle anti-ghost dead time at each digit change;
- per-digit blinking, used for the time-set mode;
- optional leading-zero blanking.

It sits between the time-keeping counters and the board's shared-segment display pins.

---
 rtl/seven_seg_scan.sv | 165 ++++++++++++++++
 tb/tb_seven_seg_scan.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scan.sv
// -----------------------------------------------------------------------------
// seven_seg_scan
//
// Time-multiplexed seven-segment display driver. A shadow register holds
// NUM_DIGITS BCD digits. The driver scans them one at a time onto a shared
// active-low segment bus, with active-low anode enables.
//
// Features:
//   - one dead cycle at the start of every digit slot (anti-ghosting);
//   - per-digit blinking, with a half-period of BLINK_FRAMES scan frames;
//   - optional leading-zero blanking, built only when the macro
//     SEVEN_SEG_SCAN_LZ_BLANK_EN is defined.
//
// Parameters:
//   NUM_DIGITS    digits scanned (>= 2)
//   REFRESH_DIV   clk cycles per digit slot (>= 2)
//   BLINK_FRAMES  full frames per blink half-period (>= 1)
//
// Ports:
//   clk         system clock
//   rst         synchronous active-high reset
//   digits      BCD digits; digit i = digits[4i+3:4i], i=0 rightmost
//   load        capture digits into the shadow register at this edge
//   blink_mask  bit i=1 makes digit i blink
//   dp_mask     bit i=1 lights the decimal point of digit i (sampled live)
//   seg         active-low segments, seg[6]=a .. seg[0]=g
//   dp          active-low decimal point
//   an          active-low anode enables, an[i] drives digit i
//   frame_tick  one-cycle pulse in the cycle after the scan index wraps to 0
// -----------------------------------------------------------------------------
module seven_seg_scan #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic                    load,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_tick
);

  localparam int PW = $clog2(REFRESH_DIV);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [PW-1:0] PRE_LAST  = PW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);
  localparam logic [FW-1:0] FCNT_LAST = FW'(BLINK_FRAMES - 1);

  logic [4*NUM_DIGITS-1:0] shadow;
  logic [PW-1:0]           pre;
  logic [IW-1:0]           idx;
  logic [FW-1:0]           fcnt;
  logic                    phase;

  logic                  pre_wrap;
  logic                  idx_wrap;
  logic                  fcnt_wrap;
  logic [3:0]            cur_digit;
  logic                  cur_blink;
  logic                  cur_dp;
  logic                  cur_lz;
  logic [NUM_DIGITS-1:0] an_sel;
  logic                  slot_off;

  // Active-low segment pattern; every non-BCD value shows "E".
  function automatic logic [6:0] encode(input logic [3:0] v);
    case (v)
      4'd0:    encode = 7'b0000001;
      4'd1:    encode = 7'b1001111;
      4'd2:    encode = 7'b0010010;
      4'd3:    encode = 7'b0000110;
      4'd4:    encode = 7'b1001100;
      4'd5:    encode = 7'b0100100;
      4'd6:    encode = 7'b0100000;
      4'd7:    encode = 7'b0001111;
      4'd8:    encode = 7'b0000000;
      4'd9:    encode = 7'b0001100;
      default: encode = 7'b0110000;
    endcase
  endfunction

  assign pre_wrap  = (pre == PRE_LAST);
  assign idx_wrap  = pre_wrap && (idx == IDX_LAST);
  assign fcnt_wrap = idx_wrap && (fcnt == FCNT_LAST);

  // Select the current digit, its mask bits and its anode from idx.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    cur_digit = '0;
    cur_blink = 1'b0;
    cur_dp    = 1'b0;
    cur_lz    = 1'b0;
    an_sel    = '1;
`ifdef SEVEN_SEG_SCAN_LZ_BLANK_EN
    begin : lz_scan
      // lead_zero[i] is set when digit i and every more-significant digit are 0.
      logic [NUM_DIGITS-1:0] lead_zero;
      lead_zero[NUM_DIGITS-1] = (shadow[4*(NUM_DIGITS-1) +: 4] == 4'd0);
      for (int i = NUM_DIGITS - 2; i >= 0; i--) begin
        lead_zero[i] = lead_zero[i+1] && (shadow[4*i +: 4] == 4'd0);
      end
      for (int i = 1; i < NUM_DIGITS; i++) begin
        if (idx == IW'(i)) cur_lz = lead_zero[i];
      end
    end
`endif
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IW'(i)) begin
        cur_digit = shadow[4*i +: 4];
        cur_blink = blink_mask[i];
        cur_dp    = dp_mask[i];
        an_sel[i] = 1'b0;
      end
    end
  end

  // Dead cycle at the start of a slot, a blinking digit in its dark phase,
  // and a blanked leading zero all turn the whole display off.
  assign slot_off = (pre == '0) || (phase && cur_blink) || cur_lz;

  always_ff @(posedge clk) begin
    // NOTE: registered state uses non-blocking assignments, so every
    // right-hand side sees the values from before this edge.
    if (rst) begin
      // The shadow register is reset too, so the display shows zeros
      // instead of stale or undefined digits after a reset.
      shadow     <= '0;
      pre        <= '0;
      idx        <= '0;
      fcnt       <= '0;
      phase      <= 1'b0;
      seg        <= '1;
      dp         <= 1'b1;
      an         <= '1;
      frame_tick <= 1'b0;
    end else begin
      if (load) shadow <= digits;

      pre <= pre_wrap ? '0 : pre + PW'(1);
      if (pre_wrap) idx <= idx_wrap ? '0 : idx + IW'(1);
      if (idx_wrap) fcnt <= fcnt_wrap ? '0 : fcnt + FW'(1);
      if (fcnt_wrap) phase <= ~phase;
      frame_tick <= idx_wrap;

      if (slot_off) begin
        seg <= '1;
        dp  <= 1'b1;
        an  <= '1;
      end else begin
        seg <= encode(cur_digit);
        dp  <= ~cur_dp;
        an  <= an_sel;
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_scan.sv
// -----------------------------------------------------------------------------
// tb_seven_seg_scan
//
// Self-checking bench for seven_seg_scan with NUM_DIGITS=4, REFRESH_DIV=4 and
// BLINK_FRAMES=2.
//
// The reference model counts the cycles elapsed since reset. From that count
// it derives the slot position, scan index and blink phase by division and
// modulo, and keeps its own copy of the loaded digits.
//
// The stimulus is a directed sequence followed by a randomized phase.
// -----------------------------------------------------------------------------
module tb_seven_seg_scan;

  localparam int N = 4;
  localparam int R = 4;
  localparam int B = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [4*N-1:0] digits;
  logic          load;
  logic [N-1:0]  blink_mask;
  logic [N-1:0]  dp_mask;
  logic [6:0]    seg;
  logic          dp;
  logic [N-1:0]  an;
  logic          frame_tick;

  int compared   = 0;
  int mismatched = 0;

  // Model state: cycles since reset, and the digits most recently loaded.
  int        cnt      = 0;
  logic [15:0] m_shadow = '0;

  seven_seg_scan #(
    .NUM_DIGITS  (N),
    .REFRESH_DIV (R),
    .BLINK_FRAMES(B)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .digits     (digits),
    .load       (load),
    .blink_mask (blink_mask),
    .dp_mask    (dp_mask),
    .seg        (seg),
    .dp         (dp),
    .an         (an),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] enc(input int v);
    case (v)
      0:       return 7'b0000001;
      1:       return 7'b1001111;
      2:       return 7'b0010010;
      3:       return 7'b0000110;
      4:       return 7'b1001100;
      5:       return 7'b0100100;
      6:       return 7'b0100000;
      7:       return 7'b0001111;
      8:       return 7'b0000000;
      9:       return 7'b0001100;
      default: return 7'b0110000;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s at cnt=%0d: observed %0h expected %0h", tag, cnt, got, exp);
    end
  endtask

  // Advance one clock. The expected outputs come from the model state and the
  // inputs before the edge; the DUT outputs are compared 1 ns after the edge.
  task automatic step();
    int         pre, idx, ph, dv;
    logic       off;
    logic [6:0] e_seg;
    logic       e_dp, e_ft;
    logic [3:0] e_an;
    if (rst) begin
      e_seg = 7'h7f; e_dp = 1'b1; e_an = 4'hf; e_ft = 1'b0;
    end else begin
      pre = cnt % R;
      idx = (cnt / R) % N;
      ph  = ((cnt / (R * N)) / B) % 2;
      dv  = int'((m_shadow >> (4 * idx)) & 16'h000f);
      off = (pre == 0) || (ph == 1 && blink_mask[idx]);
`ifdef SEVEN_SEG_SCAN_LZ_BLANK_EN
      if (idx >= 1 && (m_shadow >> (4 * idx)) == 16'h0) off = 1'b1;
`endif
      if (off) begin
        e_seg = 7'h7f; e_dp = 1'b1; e_an = 4'hf;
      end else begin
        e_seg = enc(dv);
        e_dp  = ~dp_mask[idx];
        e_an  = ~(4'b0001 << idx);
      end
      e_ft = ((cnt + 1) % (R * N)) == 0;
    end
    @(posedge clk);
    if (rst) begin
      cnt = 0;
      m_shadow = '0;
    end else begin
      cnt++;
      if (load) m_shadow = digits;
    end
    #1;
    check("seg", 32'(seg), 32'(e_seg));
    check("dp", 32'(dp), 32'(e_dp));
    check("an", 32'(an), 32'(e_an));
    check("frame_tick", 32'(frame_tick), 32'(e_ft));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic load_value(input logic [15:0] v);
    digits = v;
    load   = 1'b1;
    step();
    load   = 1'b0;
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; digits = '0; blink_mask = '0; dp_mask = '0;
    #2;
    run(2);
    rst = 1'b0;

    // Scan of 1234, dead cycles and frame_tick spacing.
    load_value(16'h1234);
    run(40);

    // Non-BCD digits and zeros in the upper positions.
    load_value(16'h00af);
    run(36);

    // All zeros.
    load_value(16'h0000);
    run(36);

    // Blink digit 2 over several blink half-periods.
    load_value(16'h1234);
    blink_mask = 4'b0100;
    run(80);
    blink_mask = '0;

    // Decimal point on digit 2 only.
    dp_mask = 4'b0100;
    run(20);
    dp_mask = '0;

    // Reset in the middle of digit 2's slot, followed by the recovery scan.
    for (int i = 0; i < 4 * R * N; i++) begin
      if (((cnt / R) % N) == 2 && (cnt % R) == 1) break;
      step();
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    run(20);

    // Load asserted together with reset: the reset wins.
    load_value(16'h5678);
    rst = 1'b1; digits = 16'hffff; load = 1'b1;
    step();
    rst = 1'b0; load = 1'b0;
    run(20);

    // Mid-frame load.
    run(6);
    load_value(16'h9087);
    run(20);

    // Randomized phase.
    for (int i = 0; i < 2000; i++) begin
      load = 1'b0;
      if ($urandom_range(7) == 0) begin
        digits = 16'($urandom);
        // Zero some upper nibbles so leading-zero cases come up often.
        case ($urandom_range(3))
          0: digits[15:12] = 4'h0;
          1: digits[15:8]  = 8'h00;
          2: digits[15:4]  = 12'h000;
          default: ;
        endcase
        load = 1'b1;
      end
      if ($urandom_range(49) == 0) blink_mask = 4'($urandom);
      dp_mask = 4'($urandom);
      rst = ($urandom_range(299) == 0);
      step();
    end
    rst = 1'b0; load = 1'b0;
    run(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
